// File: rtl/mac_op_scheduler.sv
// Round-robin issue of add/multiply ops from two requesters onto one shared
// datapath, with tag tracking that routes each result back to its requester.
// Ports: clk_i/reset_n, stall_i, req{0,1}_{valid,ready,op,a,b},
//        dp_{sel,input1,input2}, dp_selected, rsp{0,1}_valid, rsp_data, busy.
module mac_op_scheduler #(
  parameter int LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       stall_i,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       dp_sel,
  output logic [3:0] dp_input1,
  output logic [3:0] dp_input2,
  input  logic [7:0] dp_selected,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_data,
  output logic       busy
);

  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic               ok;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;

  assign ok = reset_n & ~stall_i;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      ok & req0_valid & req1_valid: begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end
      ok & req0_valid & ~req1_valid: grant0 = 1'b1;
      ok & req1_valid & ~req0_valid: grant1 = 1'b1;
      default: ;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      dp_sel     <= 1'b0;
      dp_input1  <= '0;
      dp_input2  <= '0;
    end else if (accept) begin
      last_grant <= grant1;
      dp_sel     <= grant1 ? req1_op : req0_op;
      dp_input1  <= grant1 ? req1_a : req0_a;
      dp_input2  <= grant1 ? req1_b : req0_b;
    end
  end

  // Tag stages follow the op through the datapath; the response
  // registers add the final edge so rsp lines up with dp_selected.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      tag_v      <= '0;
      tag_id     <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      tag_v[0]  <= accept;
      tag_id[0] <= grant1;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      rsp0_valid <= tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
      rsp1_valid <= tag_v[LATENCY-1] & tag_id[LATENCY-1];
    end
  end

  assign rsp_data = dp_selected;
  assign busy     = |tag_v;

endmodule

// File: tb/tb_mac_op_scheduler.sv
// Bench for mac_op_scheduler: datapath stand-in, queue-based reference model
// checked every cycle, directed cases and a randomized phase.
module tb_mac_op_scheduler;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       stall_i = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic       req0_op = 1'b0;
  logic [3:0] req0_a = '0;
  logic [3:0] req0_b = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic       req1_op = 1'b0;
  logic [3:0] req1_a = '0;
  logic [3:0] req1_b = '0;
  logic       dp_sel;
  logic [3:0] dp_input1;
  logic [3:0] dp_input2;
  logic [7:0] dp_selected;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [7:0] rsp_data;
  logic       busy;

  always #5 clk = ~clk;

  mac_op_scheduler #(.LATENCY(L)) dut (
    .clk_i(clk), .reset_n(reset_n), .stall_i(stall_i),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .dp_sel(dp_sel), .dp_input1(dp_input1), .dp_input2(dp_input2),
    .dp_selected(dp_selected),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the add_or_multiply datapath.
  logic [7:0] dps [L];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) dps[i] <= '0;
    end else begin
      dps[0] <= dp_sel ? 8'(dp_input1 * dp_input2)
                       : 8'(dp_input1 + dp_input2);
      for (int i = 1; i < L; i++) dps[i] <= dps[i-1];
    end
  end
  assign dp_selected = dps[L-1];

  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Reference model
  typedef struct {
    int due;
    bit id;
    int val;
  } rsp_t;

  rsp_t q[$];
  bit   lg = 1'b1;
  int   cyc = 0;
  int   e_sel = 0;
  int   e_a = 0;
  int   e_b = 0;

  function automatic void mgrant(output bit m0, output bit m1);
    m0 = 1'b0;
    m1 = 1'b0;
    if (reset_n && !stall_i) begin
      if (req0_valid && req1_valid) begin
        m0 = lg;
        m1 = !lg;
      end else begin
        m0 = req0_valid;
        m1 = req1_valid;
      end
    end
  endfunction

  always @(posedge clk or negedge clk) begin
    bit   m0, m1, r0, r1;
    int   d;
    rsp_t e;
    if (clk) begin
      cyc++;
      mgrant(m0, m1);
      if (m0 | m1) begin
        e.due = cyc + L;
        e.id  = m1;
        e_sel = m1 ? int'(req1_op) : int'(req0_op);
        e_a   = m1 ? int'(req1_a) : int'(req0_a);
        e_b   = m1 ? int'(req1_b) : int'(req0_b);
        e.val = e_sel != 0 ? e_a * e_b : e_a + e_b;
        q.push_back(e);
        lg = m1;
      end
    end else begin
      if (!reset_n) begin
        q.delete();
        lg = 1'b1;
        e_sel = 0;
        e_a = 0;
        e_b = 0;
      end
      mgrant(m0, m1);
      chk("req0_ready", int'(req0_ready), int'(m0));
      chk("req1_ready", int'(req1_ready), int'(m1));
      r0 = 1'b0;
      r1 = 1'b0;
      d = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r0 = !q[0].id;
        r1 = q[0].id;
        d  = q[0].val;
        void'(q.pop_front());
      end
      chk("rsp0_valid", int'(rsp0_valid), int'(r0));
      chk("rsp1_valid", int'(rsp1_valid), int'(r1));
      if (r0 | r1) chk("rsp_data", int'(rsp_data), d);
      else chk("rsp_data_raw", int'(rsp_data), int'(dp_selected));
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("dp_sel", int'(dp_sel), e_sel);
      chk("dp_input1", int'(dp_input1), e_a);
      chk("dp_input2", int'(dp_input2), e_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(bit id, bit op, int a, int b, int exp);
    bit acc;
    acc = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_op = op;
      req1_a = 4'(a); req1_b = 4'(b);
    end else begin
      req0_valid = 1'b1; req0_op = op;
      req0_a = 4'(a); req0_b = 4'(b);
    end
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = id ? req1_ready : req0_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("accept_seen", int'(acc), 1);
    chk("lit_dp_sel", int'(dp_sel), int'(op));
    chk("lit_dp_in1", int'(dp_input1), a);
    chk("lit_dp_in2", int'(dp_input2), b);
    repeat (L) tick();
    chk("lit_rsp_valid", int'(id ? rsp1_valid : rsp0_valid), 1);
    chk("lit_rsp_other", int'(id ? rsp0_valid : rsp1_valid), 0);
    chk("lit_rsp_data", int'(rsp_data), exp);
  endtask

  initial begin
    bit acc0, acc1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    single(0, 0, 3, 5, 8);
    single(1, 1, 15, 15, 225);
    single(1, 0, 15, 15, 30);
    single(1, 1, 0, 9, 0);

    repeat (5) tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_dp_sel", int'(dp_sel), 1);
    chk("idle_dp_in2", int'(dp_input2), 9);

    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 4'd2; req0_b = 4'd2;
    req1_valid = 1'b1; req1_op = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ready0", int'(req0_ready), int'(i % 2 == 0));
      chk("rr_ready1", int'(req1_ready), int'(i % 2 == 1));
      tick();
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", int'(req0_ready | req1_ready), 0);
      tick();
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("post_stall_r0", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (L + 2) tick();

    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd4;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd2;
    repeat (2) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp", int'(rsp0_valid | rsp1_valid), 0);
    chk("rst_dp_in1", int'(dp_input1), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    single(1, 1, 7, 6, 42);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      if (!req0_valid || acc0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_op = 1'($urandom_range(0, 1));
        req0_a = 4'($urandom_range(0, 15));
        req0_b = 4'($urandom_range(0, 15));
      end
      if (!req1_valid || acc1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_op = 1'($urandom_range(0, 1));
        req1_a = 4'($urandom_range(0, 15));
        req1_b = 4'($urandom_range(0, 15));
      end
      stall_i = ($urandom_range(0, 7) == 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    stall_i = 1'b0;
    repeat (L + 4) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mac_op_scheduler.md
Name: mac_op_scheduler

Overview:
- Shares one add_or_multiply datapath between two requesters.
- Arbitrates operation requests round-robin and drives the datapath operand/select inputs.
- Tracks each issued op through the datapath's fixed pipeline latency and routes the 8-bit result back to the originating requester.
- Sits between the requester logic and the add_or_multiply instance. Up to one issue per cycle, fully pipelined.

Parameters:
- LATENCY, 2, clock edges from operands/select registered on dp_* to the matching result on dp_selected (1..4 legal).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_i  in  1  high blocks new grants. In-flight ops still complete.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  1  0 = add, 1 = multiply.
- req0_a  in  4  operand 1.
- req0_b  in  4  operand 2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- dp_sel  out  1  to datapath sel (0 = added, 1 = multiplied).
- dp_input1  out  4  to datapath input1.
- dp_input2  out  4  to datapath input2.
- dp_selected  in  8  from datapath selected.
- rsp0_valid  out  1  result for requester 0 on rsp_data this cycle.
- rsp1_valid  out  1  result for requester 1 on rsp_data this cycle.
- rsp_data  out  8  result value.
- busy  out  1  any op in flight.

Behaviour:
- Reset (async assert, sync release): dp_sel, dp_input1 and dp_input2 = 0. Tag pipeline cleared. rsp0_valid, rsp1_valid and busy = 0. last_grant = 1, so requester 0 wins first.
- Handshake: reqk_ready is combinational and equals grant_k. Grant_k is active only while reqk_valid=1 and stall_i=0. An op is accepted at a rising edge E where reqk_valid and reqk_ready are both 1.
- At most one ready is high per cycle. Requesters hold valid/op/a/b stable until accepted. The scheduler must not depend on valid staying high once ready was low.
- Arbitration, round-robin:
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - last_grant updates only on an accepted op.
- Issue: at edge E the accepted op loads dp_sel=op, dp_input1=a and dp_input2=b. When no op is accepted, dp_* hold their previous values.
- Tag pipeline: LATENCY stages of {valid, id}, loaded at E and shifted every edge. Ops are never dropped or reordered.
- Response: rspk_valid is high for exactly one cycle, the cycle after edge E+LATENCY, where k is the requester id. rsp_data = dp_selected, combinational, valid only while a rspk_valid is high; otherwise it equals dp_selected unqualified. rsp0_valid and rsp1_valid are never high together. There is no response backpressure.
- Throughput: back-to-back accepts every cycle are legal and produce back-to-back responses in issue order.
- Arithmetic, from the datapath:
  - add = zero-extended 5-bit sum, max 30.
  - multiply = full 8-bit product, max 225.
- busy = OR of all tag-stage valids.
- stall_i is sampled combinationally: ready is 0 in any cycle with stall_i=1.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is issued for them. After release, the first grant goes to requester 0.

Test Plan:
- Single add, LATENCY=2: req0 op=0 a=3 b=5 accepted at edge 0 → dp_sel=0, dp_input1=3, dp_input2=5 after edge 0. rsp0_valid=1 with rsp_data=8 only in the cycle after edge 2. rsp1_valid stays 0.
- Multiply boundary: req1 op=1 a=15 b=15 → rsp1 rsp_data=225. Then op=0 a=15 b=15 → 30. Then op=1 a=0 b=9 → 0.
- Contention: both valid continuously, req0 always 2+2 add and req1 always 3×3 multiply, 6 cycles → grants 0,1,0,1,0,1 with one ready per cycle. Responses alternate 4,9,4,9,4,9 with matching rsp0_valid/rsp1_valid, one per cycle, no gaps.
- Stall: both valid, stall_i=1 for 3 cycles → both readys 0, and dp_* hold. In-flight op still responds. After stall_i=0 the grant continues the round-robin order.
- Reset mid-flight: accept two ops, then assert reset_n=0 one edge later → all outputs 0 immediately and busy=0. No rsp_valid after release. A new req1-only op is accepted first and responds correctly.
- Idle hold: no valid for 5 cycles → readys 0, busy=0, rsp valids 0, dp_* unchanged from the last issued op.
